// File: rtl/writeback_regfile.sv
// Write-back select plus 32-entry register file with two combinational read ports and a registered commit-trace port.
// Optional build macro REGFILE_BYPASS_EN enables same-cycle write-through forwarding to the read ports.
module writeback_regfile #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             regwr,
   input  logic [1:0]       regdst,
   input  logic [1:0]       memtoreg,
   input  logic [4:0]       rs,
   input  logic [4:0]       rt,
   input  logic [4:0]       rd,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [WIDTH-1:0] mem_data,
   input  logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] rd_data1,
   output logic [WIDTH-1:0] rd_data2,
   output logic             wb_valid,
   output logic [4:0]       wb_addr,
   output logic [WIDTH-1:0] wb_data
);

   localparam int unsigned AW = 5;

   logic [WIDTH-1:0] regs [NREGS];
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic             sel_ok;
   logic             commit;

   // Write address / data muxes; reserved encodings fall to zero and are blocked by sel_ok.
   always_comb begin
      waddr = '0;
      wdata = '0;
      unique case (regdst)
         2'b00:   waddr = rt;
         2'b01:   waddr = rd;
         2'b10:   waddr = AW'(31);
         default: waddr = '0;
      endcase
      unique case (memtoreg)
         2'b00:   wdata = alu_result;
         2'b01:   wdata = mem_data;
         2'b10:   wdata = pc_plus4;
         default: wdata = '0;
      endcase
   end

   assign sel_ok = (regdst != 2'b11) && (memtoreg != 2'b11);
   assign commit = regwr && sel_ok && (waddr != '0);

   // Register array and commit-trace state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
      end else begin
         wb_valid <= commit;
         if (commit) begin
            regs[waddr] <= wdata;
            wb_addr     <= waddr;
            wb_data     <= wdata;
         end
      end
   end

   // Read ports; $0 always reads zero regardless of array contents or forwarding.
   always_comb begin
      rd_data1 = '0;
      rd_data2 = '0;
      if (rs != '0) rd_data1 = regs[rs];
      if (rt != '0) rd_data2 = regs[rt];
`ifdef REGFILE_BYPASS_EN
      if (commit && (rs == waddr)) rd_data1 = wdata;
      if (commit && (rt == waddr)) rd_data2 = wdata;
`else
`endif
   end

endmodule
